// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the instruction-ROM port arbiter: response-owner encoding and the
// fetch NOP word. `INST_NOP normally comes from ins_defines.v; a fallback is provided here.
`ifndef INST_NOP
`define INST_NOP 32'h00000001
`endif

package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam logic [31:0] INST_NOP = `INST_NOP;

endpackage

// File: rtl/rom_arb_resp_track.sv
// Tracks which requester owns the ROM read data returning this cycle and routes it,
// squashing a fetch response when a jump is taken in the same cycle.
module rom_arb_resp_track
    import rom_port_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic          if_gnt,
    input  logic          dm_rd_gnt,
    input  logic [DW-1:0] rom_rdata_i,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    output logic          dm_rvalid_o,
    output logic [DW-1:0] dm_rdata_o
);

    owner_e owner, owner_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // A write grant leaves no response behind, so it falls through to OWN_NONE.
    always_comb begin
        owner_nxt   = OWN_NONE;
        if_rvalid_o = 1'b0;
        if_rdata_o  = DW'(INST_NOP);
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;

        if (if_gnt) begin
            owner_nxt = OWN_IF;
        end else if (dm_rd_gnt) begin
            owner_nxt = OWN_DM;
        end

        case (owner)
            OWN_IF: begin
                if (!jump_en_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = rom_rdata_i;
                end
            end
            OWN_DM: begin
                dm_rvalid_o = 1'b1;
                dm_rdata_o  = rom_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-ported instruction ROM between fetch and data paths with a
// combinational per-cycle grant. Define ROM_ARB_FAIR_EN to bound data bursts against fetch.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DM_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    input  logic [3:0]    dm_be_i,
    output logic          dm_gnt_o,
    output logic          dm_rvalid_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          rom_ce_o,
    output logic          rom_we_o,
    output logic [AW-1:0] rom_addr_o,
    output logic [DW-1:0] rom_wdata_o,
    output logic [3:0]    rom_be_o,
    input  logic [DW-1:0] rom_rdata_i,
    output logic          hold_flag_o
);

    if (MAX_DM_BURST < 1) begin : g_bad_burst
        $error("MAX_DM_BURST must be at least 1");
    end

    // Grants stay off from reset assertion until the first clock edge after release.
    logic run_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef ROM_ARB_FAIR_EN
    localparam int CW = $clog2(MAX_DM_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DM_BURST);

    logic [CW-1:0] burst_cnt;
    logic          fetch_turn;

    assign fetch_turn = (burst_cnt == BURST_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
        end else if (if_gnt_o || !if_req_i) begin
            burst_cnt <= '0;
        end else if (dm_gnt_o && !fetch_turn) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`else
    logic fetch_turn;

    assign fetch_turn = 1'b0;
`endif

    assign dm_gnt_o    = run_q & dm_req_i & ~(if_req_i & fetch_turn);
    assign if_gnt_o    = run_q & if_req_i & ~dm_gnt_o;
    assign hold_flag_o = run_q & if_req_i & ~if_gnt_o;

    always_comb begin
        rom_ce_o    = 1'b0;
        rom_we_o    = 1'b0;
        rom_addr_o  = '0;
        rom_wdata_o = '0;
        rom_be_o    = 4'h0;
        if (dm_gnt_o) begin
            rom_ce_o    = 1'b1;
            rom_we_o    = dm_we_i;
            rom_addr_o  = dm_addr_i;
            rom_wdata_o = dm_wdata_i;
            rom_be_o    = dm_be_i;
        end else if (if_gnt_o) begin
            rom_ce_o   = 1'b1;
            rom_addr_o = if_addr_i;
            rom_be_o   = 4'hF;
        end
    end

    rom_arb_resp_track #(
        .DW(DW)
    ) u_resp_track (
        .clk        (clk),
        .rst        (rst),
        .jump_en_i  (jump_en_i),
        .if_gnt     (if_gnt_o),
        .dm_rd_gnt  (dm_gnt_o & ~dm_we_i),
        .rom_rdata_i(rom_rdata_i),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o (dm_rdata_o)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: a behavioural ROM plus a response scoreboard.
// Fair-mode expectations follow ROM_ARB_FAIR_EN when it is defined for the build.
module tb_rom_port_arbiter;
    import rom_port_arbiter_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          jump_en_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i = 1'b0;
    logic          dm_we_i = 1'b0;
    logic [AW-1:0] dm_addr_i = '0;
    logic [DW-1:0] dm_wdata_i = '0;
    logic [3:0]    dm_be_i = 4'h0;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          rom_ce_o, rom_we_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_wdata_o;
    logic [3:0]    rom_be_o;
    logic [DW-1:0] rom_rdata_i = '0;
    logic          hold_flag_o;

    typedef struct {
        bit            is_if;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    resp_t e;
    int    total = 0;
    int    bad = 0;

    rom_port_arbiter #(.AW(AW), .DW(DW), .MAX_DM_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .rom_ce_o(rom_ce_o), .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o),
        .rom_wdata_o(rom_wdata_o), .rom_be_o(rom_be_o), .rom_rdata_i(rom_rdata_i),
        .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Behavioural ROM: one-cycle read latency, writes ignored.
    always @(posedge clk) begin
        if (rom_ce_o && !rom_we_o) rom_rdata_i <= rom_val(rom_addr_o);
    end

    task automatic drive_in(input bit ifr, input logic [AW-1:0] ia, input bit dr, input bit dw,
                            input logic [AW-1:0] da, input logic [DW-1:0] wd,
                            input logic [3:0] be, input bit jmp);
        if_req_i   = ifr;
        if_addr_i  = ia;
        dm_req_i   = dr;
        dm_we_i    = dw;
        dm_addr_i  = da;
        dm_wdata_i = wd;
        dm_be_i    = be;
        jump_en_i  = jmp;
    endtask

    task automatic drive_idle();
        drive_in(0, '0, 0, 0, '0, '0, 4'h0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        total++;
        if (if_gnt_o !== 1'b0 || dm_gnt_o !== 1'b0 || if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0 ||
            hold_flag_o !== 1'b0 || rom_ce_o !== 1'b0 || if_rdata_o !== INST_NOP || dm_rdata_o !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: gnt=%b%b rv=%b%b hold=%b ce=%b ifd=%h dmd=%h, want all 0, ifd=%h dmd=0",
                     if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, hold_flag_o, rom_ce_o, if_rdata_o,
                     dm_rdata_o, INST_NOP);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_in(1, 32'h4, 0, 0, '0, '0, 4'h0, 0);
        #1;
        total++;
        if (if_gnt_o !== 1'b0 || hold_flag_o !== 1'b0 || rom_ce_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release_quiet: gnt=%b hold=%b ce=%b, want 0 0 0",
                     if_gnt_o, hold_flag_o, rom_ce_o);
        end
        drive_idle();
        @(negedge clk);
        drive_in(0, '0, 1, 0, 32'h80, '0, 4'h0, 0);
        tick();
        total++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== rom_val(32'h80)) begin
            bad++;
            $display("[TB] FAIL reset_pre_dm_read: rvalid=%b data=%h, want 1 %h",
                     dm_rvalid_o, dm_rdata_o, rom_val(32'h80));
        end
        rst = 1'b0;
        #1;
        total++;
        if (dm_gnt_o !== 1'b0 || dm_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || dm_rdata_o !== '0 ||
            if_rdata_o !== INST_NOP || rom_ce_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_dm_rd: gnt=%b rv=%b%b dmd=%h ifd=%h ce=%b, want 0 00 0 %h 0",
                     dm_gnt_o, if_rvalid_o, dm_rvalid_o, dm_rdata_o, if_rdata_o, rom_ce_o, INST_NOP);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] a;
            a = AW'(i * 4);
            @(negedge clk);
            drive_in(1, a, 0, 0, '0, '0, 4'h0, 0);
            #1;
            total++;
            if (if_gnt_o !== 1'b1 || dm_gnt_o !== 1'b0 || hold_flag_o !== 1'b0 || rom_ce_o !== 1'b1 ||
                rom_we_o !== 1'b0 || rom_addr_o !== a || rom_be_o !== 4'hF) begin
                bad++;
                $display("[TB] FAIL fetch_grant[%0d]: gnt=%b%b hold=%b ce=%b we=%b addr=%h be=%h, want 10 0 1 0 %h f",
                         i, if_gnt_o, dm_gnt_o, hold_flag_o, rom_ce_o, rom_we_o, rom_addr_o, rom_be_o, a);
            end
            exp_q.push_back('{is_if: 1'b1, data: rom_val(a)});
            tick();
            e = exp_q.pop_front();
            total++;
            if (if_rvalid_o !== 1'b1 || if_rdata_o !== e.data || dm_rvalid_o !== 1'b0 || hold_flag_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL fetch_resp[%0d]: rv=%b%b data=%h hold=%b, want 10 %h 0",
                         i, if_rvalid_o, dm_rvalid_o, if_rdata_o, hold_flag_o, e.data);
            end
        end
        @(negedge clk);
        drive_idle();
        tick();
    endtask

    task automatic test_contention();
        @(negedge clk);
        drive_in(1, 32'h10, 1, 0, 32'h100, '0, 4'hF, 0);
        #1;
        total++;
        if (dm_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || hold_flag_o !== 1'b1 || rom_addr_o !== 32'h100) begin
            bad++;
            $display("[TB] FAIL contention_grant: dm=%b if=%b hold=%b addr=%h, want 1 0 1 00000100",
                     dm_gnt_o, if_gnt_o, hold_flag_o, rom_addr_o);
        end
        exp_q.push_back('{is_if: 1'b0, data: rom_val(32'h100)});
        @(negedge clk);
        drive_idle();
        #1;
        e = exp_q.pop_front();
        total++;
        if (dm_rvalid_o !== 1'b1 || dm_rdata_o !== e.data || if_rvalid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL contention_resp: dm_rv=%b data=%h if_rv=%b, want 1 %h 0",
                     dm_rvalid_o, dm_rdata_o, if_rvalid_o, e.data);
        end
        tick();
    endtask

    task automatic test_jump_squash();
        @(negedge clk);
        drive_in(1, 32'h20, 0, 0, '0, '0, 4'h0, 0);
        #1;
        total++;
        if (if_gnt_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL squash_pre_grant: gnt=%b, want 1", if_gnt_o);
        end
        @(negedge clk);
        drive_in(1, 32'h30, 0, 0, '0, '0, 4'h0, 1);
        #1;
        total++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== INST_NOP || if_gnt_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL jump_squash: rv=%b data=%h gnt=%b, want 0 %h 1",
                     if_rvalid_o, if_rdata_o, if_gnt_o, INST_NOP);
        end
        exp_q.push_back('{is_if: 1'b1, data: rom_val(32'h30)});
        @(negedge clk);
        drive_idle();
        #1;
        e = exp_q.pop_front();
        total++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== e.data) begin
            bad++;
            $display("[TB] FAIL jump_target_resp: rv=%b data=%h, want 1 %h", if_rvalid_o, if_rdata_o, e.data);
        end
        tick();
    endtask

    task automatic test_dm_write();
        @(negedge clk);
        drive_in(1, 32'h50, 1, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 0);
        #1;
        total++;
        if (dm_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || hold_flag_o !== 1'b1 || rom_we_o !== 1'b1 ||
            rom_be_o !== 4'b0011 || rom_addr_o !== 32'h40 || rom_wdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL dm_write_port: gnt=%b%b hold=%b we=%b be=%b addr=%h wd=%h, want 01 1 1 0011 00000040 deadbeef",
                     if_gnt_o, dm_gnt_o, hold_flag_o, rom_we_o, rom_be_o, rom_addr_o, rom_wdata_o);
        end
        @(negedge clk);
        drive_idle();
        #1;
        total++;
        if (if_rvalid_o !== 1'b0 || dm_rvalid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dm_write_no_resp: rv=%b%b, want 00", if_rvalid_o, dm_rvalid_o);
        end
        tick();
    endtask

    task automatic test_fair();
        int cnt;
        bit want_if;
        cnt = 0;
        @(negedge clk);
        drive_in(1, 32'h300, 1, 0, 32'h200, '0, 4'hF, 0);
        for (int i = 0; i < 6; i++) begin
`ifdef ROM_ARB_FAIR_EN
            want_if = (cnt == MAX_BURST);
            cnt     = want_if ? 0 : cnt + 1;
`else
            want_if = 1'b0;
`endif
            #1;
            total++;
            if (if_gnt_o !== want_if || dm_gnt_o !== !want_if || hold_flag_o !== !want_if) begin
                bad++;
                $display("[TB] FAIL fair_grant[%0d]: if=%b dm=%b hold=%b, want %b %b %b",
                         i, if_gnt_o, dm_gnt_o, hold_flag_o, want_if, !want_if, !want_if);
            end
            exp_q.push_back('{is_if: want_if, data: want_if ? rom_val(32'h300) : rom_val(32'h200)});
            tick();
            e = exp_q.pop_front();
            total++;
            if (e.is_if ? (if_rvalid_o !== 1'b1 || dm_rvalid_o !== 1'b0 || if_rdata_o !== e.data)
                        : (dm_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || dm_rdata_o !== e.data)) begin
                bad++;
                $display("[TB] FAIL fair_resp[%0d]: rv=%b%b ifd=%h dmd=%h, want if=%b data=%h",
                         i, if_rvalid_o, dm_rvalid_o, if_rdata_o, dm_rdata_o, e.is_if, e.data);
            end
            @(negedge clk);
        end
        drive_idle();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: left=%0d, want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_jump_squash();
        test_dm_write();
        test_fair();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
